// File: rtl/rgb_pkg.sv
// rgb_pkg: constants shared between the serial-input FIFO feeder and the
// RGBW output stage that drains the same 32-bit FIFO.
//   - FIFO word bit positions (valid, stream_reset, G/R/B data fields)
//   - default decode timing in 96 MHz clocks
//   - decoder state encoding and FIFO word builders
package rgb_pkg;

    localparam int FIFO_W = 32;

    localparam int bnum_valid            = 31;
    localparam int bnum_stream_reset     = 30;
    localparam int bnum_g_first_data_bit = 23;
    localparam int bnum_g_last_data_bit  = 16;
    localparam int bnum_r_first_data_bit = 15;
    localparam int bnum_r_last_data_bit  = 8;
    localparam int bnum_b_first_data_bit = 7;
    localparam int bnum_b_last_data_bit  = 0;

    localparam int RGB_T_MIN_HIGH_DEF = 10;
    localparam int RGB_T_THRESH_DEF   = 58;
    localparam int RGB_T_MAX_HIGH_DEF = 150;
    localparam int RGB_STR_RST_DEF    = 4800;
    localparam int COUNTER_MAX_DEF    = 7800;

    typedef enum logic [1:0] {
        WAIT_HIGH  = 2'd0,
        HIGH       = 2'd1,
        STUCK_HIGH = 2'd2
    } rgb_state_t;

    // Pixel word: valid set, stream_reset clear, [29:24] zero, G-R-B payload.
    function automatic logic [FIFO_W-1:0] make_pixel_word(input logic [23:0] grb);
        logic [FIFO_W-1:0] w;
        w = '0;
        w[bnum_valid] = 1'b1;
        w[bnum_g_first_data_bit:bnum_g_last_data_bit] = grb[23:16];
        w[bnum_r_first_data_bit:bnum_r_last_data_bit] = grb[15:8];
        w[bnum_b_first_data_bit:bnum_b_last_data_bit] = grb[7:0];
        return w;
    endfunction

    function automatic logic [FIFO_W-1:0] make_marker_word();
        logic [FIFO_W-1:0] w;
        w = '0;
        w[bnum_valid]        = 1'b1;
        w[bnum_stream_reset] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/rgb_sinp_fifo_if.sv
// rgb_sinp_fifo_if: FIFO write-side bus between the serial-input decoder
// (master) and the shared FIFO (slave).
//   in_wr_fifo_full   FIFO full flag (FIFO -> decoder)
//   out_wr_fifo_en    one-clock write strobe (decoder -> FIFO)
//   out_wr_fifo_data  32-bit word (decoder -> FIFO)
interface rgb_sinp_fifo_if;
    import rgb_pkg::*;

    logic              in_wr_fifo_full;
    logic              out_wr_fifo_en;
    logic [FIFO_W-1:0] out_wr_fifo_data;

    modport master (
        input  in_wr_fifo_full,
        output out_wr_fifo_en,
        output out_wr_fifo_data
    );

    modport slave (
        output in_wr_fifo_full,
        input  out_wr_fifo_en,
        input  out_wr_fifo_data
    );

endinterface

// File: rtl/rgb_sig_sync.sv
// rgb_sig_sync: brings the asynchronous WS2812b line into clk and produces
// single-clock rise/fall pulses.
//   clk, rst  clock and synchronous active-high reset
//   in_sig    asynchronous serial line
//   rise      pulse, line went 0 -> 1
//   fall      pulse, line went 1 -> 0
// Two synchronizer flops plus one history flop; the decoder acts on a pulse
// at the third clock edge after the pin changes.
module rgb_sig_sync (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= in_sig;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;
    assign fall = ~sync_2 & sync_prev;

endmodule

// File: rtl/rgb_sinp_fifo.sv
// rgb_sinp_fifo: WS2812b serial-input decoder feeding the RGBW FIFO.
//   clk, rst       96 MHz clock, synchronous active-high reset
//   in_sig         asynchronous serial line
//   wr             FIFO write bus (master side)
//   out_overflow   sticky, a word was dropped because the FIFO was full
//   out_frame_err  pulse, partial word or over-long high pulse discarded
//
// state      | meaning
// WAIT_HIGH  | line low; counting low time, watching for stream reset
// HIGH       | line high; measuring pulse width
// STUCK_HIGH | pulse exceeded max high time; waiting for the line to drop
module rgb_sinp_fifo
    import rgb_pkg::*;
#(
    parameter int RGB_T_MIN_HIGH = RGB_T_MIN_HIGH_DEF,
    parameter int RGB_T_THRESH   = RGB_T_THRESH_DEF,
    parameter int RGB_T_MAX_HIGH = RGB_T_MAX_HIGH_DEF,
    parameter int RGB_STR_RST    = RGB_STR_RST_DEF,
    parameter int COUNTER_MAX    = COUNTER_MAX_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_sig,
    rgb_sinp_fifo_if.master       wr,
    output logic                  out_overflow,
    output logic                  out_frame_err
);

    localparam int CNT_W = $clog2(COUNTER_MAX + 1);

    localparam logic [CNT_W-1:0] T_MIN   = CNT_W'(RGB_T_MIN_HIGH);
    localparam logic [CNT_W-1:0] T_TH    = CNT_W'(RGB_T_THRESH);
    localparam logic [CNT_W-1:0] T_MAX   = CNT_W'(RGB_T_MAX_HIGH);
    localparam logic [CNT_W-1:0] T_SRST  = CNT_W'(RGB_STR_RST);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(COUNTER_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sig_rise;
    logic             sig_fall;
    rgb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] low_save;
    logic [23:0]      shift;
    logic [4:0]       bit_cnt;
    logic             sr_sent;
    logic             bit_val;

    rgb_sig_sync u_sig_sync (
        .clk    (clk),
        .rst    (rst),
        .in_sig (in_sig),
        .rise   (sig_rise),
        .fall   (sig_fall)
    );

    assign cnt_inc = (cnt == CNT_TOP) ? cnt : cnt + CNT_ONE;
    assign bit_val = (cnt >= T_TH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= WAIT_HIGH;
            cnt                 <= '0;
            low_save            <= '0;
            shift               <= '0;
            bit_cnt             <= '0;
            sr_sent             <= 1'b0;
            wr.out_wr_fifo_en   <= 1'b0;
            wr.out_wr_fifo_data <= '0;
            out_overflow        <= 1'b0;
            out_frame_err       <= 1'b0;
        end else begin
            wr.out_wr_fifo_en <= 1'b0;
            out_frame_err     <= 1'b0;

            case (state)
                WAIT_HIGH: begin
                    if (sig_rise) begin
                        // Remember the low time so a glitch can restore it.
                        state    <= HIGH;
                        low_save <= cnt;
                        cnt      <= CNT_ONE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt >= T_SRST && !sr_sent) begin
                            sr_sent <= 1'b1;
                            if (wr.in_wr_fifo_full) begin
                                out_overflow <= 1'b1;
                            end else begin
                                wr.out_wr_fifo_en   <= 1'b1;
                                wr.out_wr_fifo_data <= make_marker_word();
                            end
                            if (bit_cnt != 5'd0) begin
                                out_frame_err <= 1'b1;
                            end
                            bit_cnt <= '0;
                            shift   <= '0;
                        end
                    end
                end

                HIGH: begin
                    if (sig_fall && cnt < T_MIN) begin
                        state <= WAIT_HIGH;
                        cnt   <= low_save;
                    end else if (sig_fall && cnt <= T_MAX) begin
                        state   <= WAIT_HIGH;
                        cnt     <= CNT_ONE;
                        sr_sent <= 1'b0;
                        if (bit_cnt == 5'd23) begin
                            bit_cnt <= '0;
                            shift   <= '0;
                            if (wr.in_wr_fifo_full) begin
                                out_overflow <= 1'b1;
                            end else begin
                                wr.out_wr_fifo_en   <= 1'b1;
                                wr.out_wr_fifo_data <= make_pixel_word({shift[22:0], bit_val});
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                            shift   <= {shift[22:0], bit_val};
                        end
                    end else if (cnt > T_MAX) begin
                        out_frame_err <= 1'b1;
                        bit_cnt       <= '0;
                        shift         <= '0;
                        // A fall on the very clock the limit is crossed needs no stuck wait.
                        if (sig_fall) begin
                            state <= WAIT_HIGH;
                            cnt   <= CNT_ONE;
                        end else begin
                            state <= STUCK_HIGH;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end

                STUCK_HIGH: begin
                    if (sig_fall) begin
                        state <= WAIT_HIGH;
                        cnt   <= CNT_ONE;
                    end
                end

                default: begin
                    state <= WAIT_HIGH;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgb_sinp_fifo.sv
module tb_rgb_sinp_fifo;

    logic clk = 1'b0;
    logic rst;
    logic in_sig;
    logic out_overflow;
    logic out_frame_err;

    rgb_sinp_fifo_if bus ();

    rgb_sinp_fifo dut (
        .clk           (clk),
        .rst           (rst),
        .in_sig        (in_sig),
        .wr            (bus),
        .out_overflow  (out_overflow),
        .out_frame_err (out_frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] wq[$];
    int ferr_cnt = 0;

    localparam logic [31:0] MARKER = 32'hC000_0000;

    always @(negedge clk) begin
        if (bus.out_wr_fifo_en === 1'b1) wq.push_back(bus.out_wr_fifo_data);
        if (out_frame_err === 1'b1) ferr_cnt++;
    end

    // All drives start on a negedge and last n clocks.
    task automatic drive(input logic v, input int n);
        in_sig = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        if (b) begin
            drive(1'b1, 77);
            drive(1'b0, 43);
        end else begin
            drive(1'b1, 38);
            drive(1'b0, 82);
        end
    endtask

    function automatic logic [31:0] qget(input int idx);
        if (idx < wq.size()) return wq[idx];
        return 32'hDEAD_DEAD;
    endfunction

    task automatic clear_obs();
        wq.delete();
        ferr_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_sig = 1'b0;
        bus.in_wr_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.out_wr_fifo_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", bus.out_wr_fifo_en); end
        checks++; if (bus.out_wr_fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.out_wr_fifo_data); end
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", out_overflow); end
        checks++; if (out_frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", out_frame_err); end
        clear_obs();
        rst = 1'b0;
        repeat (4790) @(negedge clk);
        checks++; if (wq.size() != 0) begin errors++; $display("FAIL early_marker: got %0d writes want 0", wq.size()); end
        repeat (20) @(negedge clk);
        checks++; if (wq.size() != 1 || qget(0) !== MARKER) begin errors++; $display("FAIL first_marker: got %0d writes word %h want 1 of %h", wq.size(), qget(0), MARKER); end
        repeat (20000) @(negedge clk);
        checks++; if (wq.size() != 1) begin errors++; $display("FAIL single_marker: got %0d writes want 1", wq.size()); end
    endtask

    task automatic test_frame();
        logic [23:0] w;
        w = 24'hA53C0F;
        clear_obs();
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
        drive(1'b0, 5000);
        checks++; if (wq.size() != 2 || qget(0) !== 32'h80A5_3C0F || qget(1) !== MARKER) begin errors++; $display("FAIL frame_words: got %0d writes %h %h want 80a53c0f c0000000", wq.size(), qget(0), qget(1)); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL frame_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_glitch();
        logic [23:0] w;
        w = 24'hA53C0F;
        clear_obs();
        for (int i = 23; i >= 0; i--) begin
            send_bit(w[i]);
            if (i == 12) begin
                drive(1'b1, 5);
                drive(1'b0, 40);
            end
        end
        drive(1'b0, 5000);
        checks++; if (wq.size() != 2 || qget(0) !== 32'h80A5_3C0F || qget(1) !== MARKER) begin errors++; $display("FAIL glitch_words: got %0d writes %h %h want 80a53c0f c0000000", wq.size(), qget(0), qget(1)); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL glitch_ferr: got %0d want 0", ferr_cnt); end
    endtask

    // High widths 58,57,10,150 decode as 1,0,0,1 -> nibble 9; a 9-clock pulse is a glitch.
    task automatic test_boundary();
        int th [4];
        th = '{58, 57, 10, 150};
        clear_obs();
        for (int i = 0; i < 24; i++) begin
            drive(1'b1, th[i % 4]);
            drive(1'b0, 60);
            if (i == 5) begin
                drive(1'b1, 9);
                drive(1'b0, 60);
            end
        end
        drive(1'b0, 5000);
        checks++; if (wq.size() != 2 || qget(0) !== 32'h8099_9999 || qget(1) !== MARKER) begin errors++; $display("FAIL boundary_words: got %0d writes %h %h want 80999999 c0000000", wq.size(), qget(0), qget(1)); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL boundary_ferr: got %0d want 0", ferr_cnt); end
    endtask

    task automatic test_partial();
        clear_obs();
        for (int i = 0; i < 10; i++) send_bit(i[0]);
        drive(1'b0, 5000);
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL partial_ferr: got %0d want 1", ferr_cnt); end
        checks++; if (wq.size() != 1 || qget(0) !== MARKER) begin errors++; $display("FAIL partial_words: got %0d writes %h want 1 of c0000000", wq.size(), qget(0)); end
    endtask

    task automatic test_stuck_high();
        clear_obs();
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        drive(1'b1, 200);
        drive(1'b0, 5000);
        checks++; if (ferr_cnt != 1) begin errors++; $display("FAIL stuck_ferr: got %0d want 1", ferr_cnt); end
        checks++; if (wq.size() != 1 || qget(0) !== MARKER) begin errors++; $display("FAIL stuck_words: got %0d writes %h want 1 of c0000000", wq.size(), qget(0)); end
    endtask

    task automatic test_fifo_full();
        logic [23:0] w;
        w = 24'h123456;
        clear_obs();
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b want 0", out_overflow); end
        bus.in_wr_fifo_full = 1'b1;
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
        bus.in_wr_fifo_full = 1'b0;
        drive(1'b0, 5000);
        checks++; if (wq.size() != 1 || qget(0) !== MARKER) begin errors++; $display("FAIL full_words: got %0d writes %h want 1 of c0000000", wq.size(), qget(0)); end
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b want 1", out_overflow); end
    endtask

    task automatic test_rst_mid();
        clear_obs();
        for (int i = 0; i < 12; i++) send_bit(1'b0);
        checks++; if (out_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", out_overflow); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (out_overflow !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b want 0", out_overflow); end
        clear_obs();
        drive(1'b0, 5000);
        for (int i = 0; i < 24; i++) send_bit(1'b1);
        drive(1'b0, 5000);
        checks++; if (wq.size() != 3 || qget(0) !== MARKER || qget(1) !== 32'h80FF_FFFF || qget(2) !== MARKER) begin errors++; $display("FAIL rst_mid_words: got %0d writes %h %h %h want c0000000 80ffffff c0000000", wq.size(), qget(0), qget(1), qget(2)); end
        checks++; if (ferr_cnt != 0) begin errors++; $display("FAIL rst_mid_ferr: got %0d want 0", ferr_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_glitch();
        test_boundary();
        test_partial();
        test_stuck_high();
        test_fifo_full();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_sinp_fifo.md
Name: rgb_sinp_fifo

Overview:
Upstream feeder of the RGBW serial-output stage. Samples the incoming WS2812b serial line and measures each high pulse to decode bits. Assembles 24-bit G-R-B pixel words and writes them, together with stream-reset marker words, into the shared 32-bit FIFO that the RGBW output stage drains. Runs on the 96 MHz PLL clock; its FIFO write side is synchronous with the FIFO w_clk.

Parameters:
RGB_T_MIN_HIGH, 10, high pulses shorter than this many clocks are glitches and are ignored
RGB_T_THRESH, 58, high time in clocks at or above which a bit decodes as "1" (~0.6 us)
RGB_T_MAX_HIGH, 150, high time in clocks above which the pulse is a framing error
RGB_STR_RST, 4800, consecutive low clocks that constitute a stream reset (50 us)
COUNTER_MAX, 7800, counter ceiling; counter width is $clog2(COUNTER_MAX+1)

Ports:
clk  input  1  96 MHz clock; the only clock
rst  input  1  synchronous, active-high reset
in_sig  input  1  asynchronous WS2812b serial line
in_wr_fifo_full  input  1  FIFO full flag
out_wr_fifo_en  output  1  FIFO write enable; one-clock pulse per word
out_wr_fifo_data  output  32  word: [31] valid=1, [30] stream_reset, [29:24]=0, [23:16] G, [15:8] R, [7:0] B
out_overflow  output  1  sticky; set when a word is dropped because the FIFO is full
out_frame_err  output  1  one-clock pulse when a partial word or an over-long high pulse is discarded

Behaviour:
- Reset (rst high at posedge): all outputs 0, shift register and bit count cleared, counter 0, state WAIT_HIGH, stream-reset-sent flag 0. Reset mid-word discards the partial bits and produces no FIFO write.
- in_sig passes through a 2-flop synchronizer plus one edge-detect register. Rise and fall are detected 3 clocks after the pin transition.
- States:
  - WAIT_HIGH: low-time counter increments, saturating at COUNTER_MAX. On a rise, go to HIGH with the counter reset to 1.
  - HIGH: counter increments.
    - On a fall with count < RGB_T_MIN_HIGH: treat as a glitch, drop the bit, return to WAIT_HIGH and keep the low count.
    - On a fall with RGB_T_MIN_HIGH <= count <= RGB_T_MAX_HIGH: shift in bit (count >= RGB_T_THRESH), MSB first; increment bit count; clear stream-reset-sent; go to WAIT_HIGH with the counter at 1.
    - If count exceeds RGB_T_MAX_HIGH while still high: pulse out_frame_err, clear the partial word, go to STUCK_HIGH.
  - STUCK_HIGH: wait for a fall, then enter WAIT_HIGH with the counter at 1.
- Word completion: when the bit count reaches 24 on a fall, on the next clock drive out_wr_fifo_data = {1,0,6'b0,shift[23:0]} and pulse out_wr_fifo_en; bit count returns to 0.
- Stream reset:
  - Triggered in WAIT_HIGH when the low count reaches RGB_STR_RST and stream-reset-sent is 0.
  - On the next clock, write {1,1,30'b0} and set stream-reset-sent, so only one marker is written per low period.
  - A nonzero bit count at this point discards the partial word and pulses out_frame_err in the same cycle as the marker write.
  - After rst the line idles low, so a single marker is written RGB_STR_RST clocks after reset release.
- FIFO full: a write is never issued while in_wr_fifo_full is high. That word is dropped and out_overflow is set; it clears only on rst. Decoding continues with no backpressure, because the serial line cannot be stalled.
- A word completion and a stream reset cannot occur in the same clock, because a stream reset needs >= 4800 low clocks after the last fall.
- Out-of-band bits: at most one write per clock; data bits [29:24] are always 0.

Decomposition:
- Package rgb_pkg holds constants shared with the output stage:
  - bnum_valid, bnum_stream_reset
  - bnum_{G,R,B}_{first,last}_data_bit
  - default timing parameters at 96 MHz
- One natural sub-module: rgb_sig_sync (2-flop synchronizer plus rise/fall pulses, with reset value 0).

Test Plan:
- Release rst with in_sig low for 4800 clocks -> exactly one write of 32'hC000_0000; no further writes while the line stays low for 20000 clocks.
- Send 24 bits encoding G=8'hA5, R=8'h3C, B=8'h0F (T0H=38/T0L=82, T1H=77/T1L=43 clocks), then 5000 low -> writes 32'h80A5_3C0F, then 32'hC000_0000.
- Insert a 5-clock high glitch between bits of the previous frame -> identical output; out_frame_err stays 0.
- Send 10 bits, then 5000 low -> out_frame_err pulses once; only 32'hC000_0000 is written.
- Hold in_wr_fifo_full=1 during the completion of one pixel -> no out_wr_fifo_en; out_overflow=1 and stays set until rst.
- Assert rst for 1 clock after 12 bits; complete the frame with 24 fresh bits of 8'hFF -> the first write after the reset marker is 32'h80FF_FFFF.
